// File: rtl/spi_byte_tx_if.sv
// rtl/spi_byte_tx_if.sv - controller-facing and serial-line signals of the SPI byte engine
interface spi_byte_tx_if;
   logic       begin_transmission;
   logic [7:0] send_data;
   logic       sdi;
   logic       sclk;
   logic       sdo;
   logic [7:0] recieved_data;
   logic       end_transmission;
   logic       busy;

   modport master (
      output begin_transmission,
      output send_data,
      output sdi,
      input  sclk,
      input  sdo,
      input  recieved_data,
      input  end_transmission,
      input  busy
   );

   modport slave (
      input  begin_transmission,
      input  send_data,
      input  sdi,
      output sclk,
      output sdo,
      output recieved_data,
      output end_transmission,
      output busy
   );
endinterface

// File: rtl/spi_byte_tx.sv
// rtl/spi_byte_tx.sv - SPI mode-3 byte transmitter for the PmodOLEDrgb serial link
module spi_byte_tx #(
   parameter int CLK_DIV = 8
) (
   input  logic         clk,
   input  logic         rst,
   spi_byte_tx_if.slave bus
);
   localparam int            DW       = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   state_t        state, state_n;
   logic          sclk_q, sclk_n;
   logic          sdo_q, sdo_n;
   logic          end_q, end_n;
   logic          busy_q, busy_n;
   logic [7:0]    rdata_q, rdata_n;
   logic [7:0]    rx_q, rx_n;
   // Bit 7 goes straight to sdo on accept, so only the remaining 7 bits are held.
   logic [6:0]    shreg_q, shreg_n;
   logic [2:0]    bit_q, bit_n;
   logic [DW-1:0] div_q, div_n;
   logic          div_last;

   assign div_last = (div_q == DIV_LAST);

   // State and every output register; reset parks the line with sclk high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sclk_q  <= 1'b1;
         sdo_q   <= 1'b0;
         end_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 8'h00;
         rx_q    <= 8'h00;
         shreg_q <= 7'h00;
         bit_q   <= 3'd0;
         div_q   <= '0;
      end else begin
         state   <= state_n;
         sclk_q  <= sclk_n;
         sdo_q   <= sdo_n;
         end_q   <= end_n;
         busy_q  <= busy_n;
         rdata_q <= rdata_n;
         rx_q    <= rx_n;
         shreg_q <= shreg_n;
         bit_q   <= bit_n;
         div_q   <= div_n;
      end
   end

   // Next-state and next-output logic: sclk low phase then high phase per bit.
   always_comb begin
      state_n = state;
      sclk_n  = sclk_q;
      sdo_n   = sdo_q;
      end_n   = 1'b0;
      busy_n  = busy_q;
      rdata_n = rdata_q;
      rx_n    = rx_q;
      shreg_n = shreg_q;
      bit_n   = bit_q;
      div_n   = div_q;
      case (state)
         IDLE: begin
            if (bus.begin_transmission) begin
               shreg_n = bus.send_data[6:0];
               sdo_n   = bus.send_data[7];
               sclk_n  = 1'b0;
               busy_n  = 1'b1;
               bit_n   = 3'd0;
               div_n   = '0;
               state_n = LOW;
            end
         end
         LOW: begin
            if (div_last) begin
               // Slave samples on this rise, so sdi is captured at the same moment.
               sclk_n  = 1'b1;
               rx_n    = {rx_q[6:0], bus.sdi};
               div_n   = '0;
               state_n = HIGH;
            end else begin
               div_n = div_q + DW'(1);
            end
         end
         HIGH: begin
            if (div_last) begin
               div_n = '0;
               if (bit_q != 3'd7) begin
                  sdo_n   = shreg_q[6];
                  shreg_n = {shreg_q[5:0], 1'b0};
                  sclk_n  = 1'b0;
                  bit_n   = bit_q + 3'd1;
                  state_n = LOW;
               end else begin
                  rdata_n = rx_q;
                  end_n   = 1'b1;
                  busy_n  = 1'b0;
                  sdo_n   = 1'b0;
                  state_n = IDLE;
               end
            end else begin
               div_n = div_q + DW'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.sclk             = sclk_q;
   assign bus.sdo              = sdo_q;
   assign bus.end_transmission = end_q;
   assign bus.busy             = busy_q;
   assign bus.recieved_data    = rdata_q;
endmodule
